// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice, LSB first,
// with start/busy/done handshake and carry/overflow flags.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               s_bit;
  logic               c_bit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    s_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
    c_bit   = (opa_q[0] & opb_q[0]) |
              (opa_q[0] & carry_q) |
              (opb_q[0] & carry_q);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // subtract = A + ~B + 1, the +1 enters as the initial carry
          opa_d   = a;
          opb_d   = mode ? ~b : b;
          carry_d = mode;
          count_d = CNT_W'(WIDTH);
          state_d = RUN;
        end
      end
      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        carry_d = c_bit;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          // carry_q here is the carry into the MSB slice
          sum_d   = res_d;
          cout_d  = c_bit;
          ovf_d   = carry_q ^ c_bit;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=8 and WIDTH=16.
module tb_serial_addsub;

  logic        clock = 1'b0;
  logic        reset;
  logic        start8, mode8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start16, mode16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  int cmp = 0;
  int bad = 0;

  always #5 clock = ~clock;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .mode(mode8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
    .carry_out(cout8), .overflow(ovf8)
  );

  serial_addsub #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .start(start16), .mode(mode16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .sum(sum16),
    .carry_out(cout16), .overflow(ovf16)
  );

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb,
                      input logic tm, input logic [7:0] es,
                      input logic ec, input logic ev,
                      input bit ign, input string nm);
    int n;
    int dn;
    bit stable;
    logic [7:0] prev;
    @(negedge clock);
    prev = sum8;
    a8 = ta; b8 = tb; mode8 = tm; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0; mode8 = ~tm; a8 = ~ta; b8 = 8'h00;
    n = 0; dn = 0; stable = 1;
    while (busy8 && n < 40) begin
      n++;
      if (sum8 !== prev) stable = 0;
      if (done8) dn++;
      start8 = (ign && n == 3);
      @(negedge clock);
    end
    start8 = 1'b0;
    cmp++;
    if (n !== 8) begin
      bad++; $display("FAIL %s busy_len: got %0d want 8", nm, n);
    end
    cmp++;
    if (done8 !== 1'b1 || dn !== 0) begin
      bad++; $display("FAIL %s done: got %b early=%0d want 1 early=0", nm, done8, dn);
    end
    cmp++;
    if (!stable) begin
      bad++; $display("FAIL %s sum_stable: partial result seen, want %h", nm, prev);
    end
    cmp++;
    if (sum8 !== es) begin
      bad++; $display("FAIL %s sum: got %h want %h", nm, sum8, es);
    end
    cmp++;
    if (cout8 !== ec || ovf8 !== ev) begin
      bad++; $display("FAIL %s flags: got c=%b v=%b want c=%b v=%b", nm, cout8, ovf8, ec, ev);
    end
    @(negedge clock);
    cmp++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      bad++; $display("FAIL %s after: got done=%b busy=%b want 0 0", nm, done8, busy8);
    end
  endtask

  task automatic run16(input logic [15:0] ta, input logic [15:0] tb,
                       input logic tm, input logic [15:0] es,
                       input logic ec, input logic ev, input string nm);
    int n;
    @(negedge clock);
    a16 = ta; b16 = tb; mode16 = tm; start16 = 1'b1;
    @(negedge clock);
    start16 = 1'b0; a16 = 16'h0; b16 = 16'h0; mode16 = ~tm;
    n = 0;
    while (busy16 && n < 60) begin
      n++;
      @(negedge clock);
    end
    cmp++;
    if (n !== 16 || done16 !== 1'b1) begin
      bad++; $display("FAIL %s busy_len: got %0d done=%b want 16 done=1", nm, n, done16);
    end
    cmp++;
    if (sum16 !== es || cout16 !== ec || ovf16 !== ev) begin
      bad++;
      $display("FAIL %s result: got %h c=%b v=%b want %h c=%b v=%b",
               nm, sum16, cout16, ovf16, es, ec, ev);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start8 = 0; mode8 = 0; a8 = 0; b8 = 0;
    start16 = 0; mode16 = 0; a16 = 0; b16 = 0;
    #12;
    cmp++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h0) begin
      bad++; $display("FAIL reset8: got %h want 000", {busy8, done8, sum8, cout8, ovf8});
    end
    cmp++;
    if ({busy16, done16, sum16, cout16, ovf16} !== 20'h0) begin
      bad++; $display("FAIL reset16: got %h want 00000", {busy16, done16, sum16, cout16, ovf16});
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_add_sub;
    run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0, "add_5a_3c");
    run8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 0, "sub_10_20");
    run8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0, "sub_80_01");
  endtask

  task automatic test_ignore_start;
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1, "add_ff_01_ign");
  endtask

  task automatic test_back_to_back;
    int n;
    int gap;
    bit stable;
    @(negedge clock);
    a8 = 8'h5A; b8 = 8'h3C; mode8 = 1'b0; start8 = 1'b1;
    @(negedge clock);
    a8 = 8'h01; b8 = 8'h02;
    n = 0;
    while (!done8 && n < 40) begin
      n++;
      @(negedge clock);
    end
    cmp++;
    if (done8 !== 1'b1 || sum8 !== 8'h96) begin
      bad++; $display("FAIL b2b_first: got done=%b sum=%h want 1 96", done8, sum8);
    end
    @(negedge clock);
    start8 = 1'b0;
    gap = 1; stable = 1;
    while (!done8 && gap < 40) begin
      if (sum8 !== 8'h96) stable = 0;
      gap++;
      @(negedge clock);
    end
    cmp++;
    if (gap !== 9) begin
      bad++; $display("FAIL b2b_gap: got %0d want 9", gap);
    end
    cmp++;
    if (!stable) begin
      bad++; $display("FAIL b2b_hold: sum left 96 before second done");
    end
    cmp++;
    if (sum8 !== 8'h03 || cout8 !== 1'b0 || ovf8 !== 1'b0) begin
      bad++; $display("FAIL b2b_second: got %h c=%b v=%b want 03 0 0", sum8, cout8, ovf8);
    end
  endtask

  task automatic test_abort;
    int dn;
    @(negedge clock);
    a8 = 8'h5A; b8 = 8'h3C; mode8 = 1'b0; start8 = 1'b1;
    @(negedge clock);
    start8 = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    cmp++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h0) begin
      bad++; $display("FAIL abort: got %h want 000", {busy8, done8, sum8, cout8, ovf8});
    end
    @(negedge clock);
    reset = 1'b0;
    dn = 0;
    repeat (12) begin
      @(negedge clock);
      if (done8 || busy8) dn++;
    end
    cmp++;
    if (dn !== 0) begin
      bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", dn);
    end
    run8(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 0, "post_abort");
  endtask

  task automatic test_width16;
    run16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "w16_add");
    run16(16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, "w16_sub");
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    test_width16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
